// File: rtl/clock_time_ctrl_pkg.sv
// Shared types and field limits for the board clock timekeeping block.
// Optional alarm feature is enabled by defining ALARM_EN.
package clock_pkg;

  localparam int HR_W    = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic [2:0] {
    MODE_RUN         = 3'd0,
    MODE_SET_HOUR    = 3'd1,
    MODE_SET_MIN     = 3'd2,
    MODE_SET_AL_HOUR = 3'd3,
    MODE_SET_AL_MIN  = 3'd4
  } mode_e;

  // Successor state on a btn_mode press; illegal codes recover to RUN.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_RUN:         return MODE_SET_HOUR;
      MODE_SET_HOUR:    return MODE_SET_MIN;
`ifdef ALARM_EN
      MODE_SET_MIN:     return MODE_SET_AL_HOUR;
      MODE_SET_AL_HOUR: return MODE_SET_AL_MIN;
`endif
      default:          return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Button/tick inputs and display-side outputs of the timekeeping controller.
// The alarm_hit wire is always present; it is only active when ALARM_EN is defined.
interface clock_time_ctrl_if;
  import clock_pkg::*;

  logic             tick_1hz;
  logic             btn_mode;
  logic             btn_inc;
  logic [HR_W-1:0]  hours;
  logic [MIN_W-1:0] minutes;
  logic [SEC_W-1:0] seconds;
  logic [2:0]       mode;
  logic             blink;
  logic             day_pulse;
  logic             alarm_hit;

  modport master (
    output tick_1hz, btn_mode, btn_inc,
    input  hours, minutes, seconds, mode, blink, day_pulse, alarm_hit
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc,
    output hours, minutes, seconds, mode, blink, day_pulse, alarm_hit
  );
endinterface

// File: rtl/clock_time_ctrl_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; carry flags an inc taken at MAX.
module wrap_counter #(
  parameter int W       = 6,
  parameter int MAX     = 59,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] RST_V = W'(RST_VAL);

  logic [W-1:0] value_q, value_d;

  // clr has priority so a same-cycle inc never leaks through a clear
  always_comb begin
    value_d = value_q;
    if (clr)
      value_d = '0;
    else if (inc)
      value_d = (value_q == MAX_V) ? '0 : value_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) value_q <= RST_V;
    else       value_q <= value_d;
  end

  assign value = value_q;
  assign carry = inc & ~clr & (value_q == MAX_V);

endmodule

// File: rtl/clock_time_ctrl.sv
// HH:MM:SS timekeeping with button-driven set mode and display blink phase.
// Define ALARM_EN to add the alarm registers, the two alarm set states and alarm_hit.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int HOURS_MAX  = 23,
  parameter int RESET_HOUR = 12,
  parameter int RESET_MIN  = 0
) (
  input  logic               clk,
  input  logic               reset,
  clock_time_ctrl_if.slave   bus
);

  mode_e            mode_q, mode_d;
  logic             blink_q, blink_d;
  logic             day_pulse_q, day_pulse_d;

  logic             run, run_tick, edit_inc;
  logic             sec_inc, sec_clr, sec_carry;
  logic             min_inc, min_carry;
  logic             hr_inc, hr_carry;
  logic [SEC_W-1:0] sec_val;
  logic [MIN_W-1:0] min_val;
  logic [HR_W-1:0]  hr_val;

  // btn_mode always wins: it suppresses both time advance and field edits
  assign run      = (mode_q == MODE_RUN);
  assign run_tick = run & bus.tick_1hz & ~bus.btn_mode;
  assign edit_inc = bus.btn_inc & ~bus.btn_mode;

  assign sec_clr  = run & bus.btn_mode;
  assign sec_inc  = run_tick;
  assign min_inc  = (run_tick & sec_carry) | ((mode_q == MODE_SET_MIN) & edit_inc);
  assign hr_inc   = (run_tick & min_carry) | ((mode_q == MODE_SET_HOUR) & edit_inc);

  wrap_counter #(.W(SEC_W), .MAX(SEC_MAX), .RST_VAL(0)) u_sec (
    .clk, .reset, .inc(sec_inc), .clr(sec_clr), .value(sec_val), .carry(sec_carry)
  );

  wrap_counter #(.W(MIN_W), .MAX(MIN_MAX), .RST_VAL(RESET_MIN)) u_min (
    .clk, .reset, .inc(min_inc), .clr(1'b0), .value(min_val), .carry(min_carry)
  );

  wrap_counter #(.W(HR_W), .MAX(HOURS_MAX), .RST_VAL(RESET_HOUR)) u_hr (
    .clk, .reset, .inc(hr_inc), .clr(1'b0), .value(hr_val), .carry(hr_carry)
  );

`ifdef ALARM_EN
  localparam logic [MIN_W-1:0] MIN_MAX_V = MIN_W'(MIN_MAX);
  localparam logic [HR_W-1:0]  HR_MAX_V  = HR_W'(HOURS_MAX);

  logic             alarm_hit_q, alarm_hit_d;
  logic             al_hr_inc, al_min_inc;
  logic             al_hr_unused_carry, al_min_unused_carry;
  logic [HR_W-1:0]  al_hr_val, hr_nxt;
  logic [MIN_W-1:0] al_min_val, min_nxt;
  logic             show_alarm;

  assign al_hr_inc  = (mode_q == MODE_SET_AL_HOUR) & edit_inc;
  assign al_min_inc = (mode_q == MODE_SET_AL_MIN) & edit_inc;
  assign show_alarm = (mode_q == MODE_SET_AL_HOUR) | (mode_q == MODE_SET_AL_MIN);

  wrap_counter #(.W(HR_W), .MAX(HOURS_MAX), .RST_VAL(0)) u_al_hr (
    .clk, .reset, .inc(al_hr_inc), .clr(1'b0), .value(al_hr_val),
    .carry(al_hr_unused_carry)
  );

  wrap_counter #(.W(MIN_W), .MAX(MIN_MAX), .RST_VAL(0)) u_al_min (
    .clk, .reset, .inc(al_min_inc), .clr(1'b0), .value(al_min_val),
    .carry(al_min_unused_carry)
  );

  // hh:mm the clock lands on when the current minute rolls over
  assign min_nxt = (min_val == MIN_MAX_V) ? '0 : min_val + 1'b1;
  assign hr_nxt  = (min_val != MIN_MAX_V) ? hr_val :
                   (hr_val == HR_MAX_V)   ? '0     : hr_val + 1'b1;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) mode_q <= MODE_RUN;
    else       mode_q <= mode_d;
  end

  // next-state
  always_comb begin
    mode_d = mode_q;
    if (bus.btn_mode)
      mode_d = next_mode(mode_q);
  end

  // outputs
  always_comb begin
    blink_d     = blink_q;
    day_pulse_d = run_tick & hr_carry;
    if (mode_d == MODE_RUN)
      blink_d = 1'b0;
    else if (!run && bus.tick_1hz)
      blink_d = ~blink_q;
`ifdef ALARM_EN
    alarm_hit_d = run_tick & sec_carry & (min_nxt == al_min_val) & (hr_nxt == al_hr_val);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q     <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      blink_q     <= blink_d;
      day_pulse_q <= day_pulse_d;
    end
  end

`ifdef ALARM_EN
  always_ff @(posedge clk) begin
    if (reset) alarm_hit_q <= 1'b0;
    else       alarm_hit_q <= alarm_hit_d;
  end

  assign bus.hours     = show_alarm ? al_hr_val  : hr_val;
  assign bus.minutes   = show_alarm ? al_min_val : min_val;
  assign bus.alarm_hit = alarm_hit_q;
`else
  assign bus.hours     = hr_val;
  assign bus.minutes   = min_val;
  assign bus.alarm_hit = 1'b0;
`endif

  assign bus.seconds   = sec_val;
  assign bus.mode      = mode_q;
  assign bus.blink     = blink_q;
  assign bus.day_pulse = day_pulse_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench: two instances (24 h dial and 12 h dial) driven in lockstep,
// each checked every cycle against a seconds-of-day reference model.
module tb_clock_time_ctrl;
  import clock_pkg::*;

`ifdef ALARM_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  initial forever #5 clk = ~clk;

  clock_time_ctrl_if ifc0();
  clock_time_ctrl_if ifc1();

  clock_time_ctrl #(.HOURS_MAX(23), .RESET_HOUR(12), .RESET_MIN(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(ifc0)
  );
  clock_time_ctrl #(.HOURS_MAX(11), .RESET_HOUR(11), .RESET_MIN(0)) u_dut1 (
    .clk(clk), .reset(reset), .bus(ifc1)
  );

  typedef struct {
    int h, m, s, mode;
    bit blink, dp, ah;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;

  // reference state: time as seconds-of-day, alarm as minutes-of-day
  int hmax[2] = '{23, 11};
  int rhr[2]  = '{12, 11};
  int t[2];
  int md[2];
  bit bl[2];
  int al[2];

  function automatic int nxt_mode(input int m);
    case (m)
      0: return 1;
      1: return 2;
      2: return ALM ? 3 : 0;
      3: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic model(input int d, input bit rst, input bit tk, input bit bm, input bit bi,
                       output exp_t e);
    int day;
    int h, m;
    bit dp, ah;
    day = (hmax[d] + 1) * 3600;
    dp = 1'b0;
    ah = 1'b0;
    if (rst) begin
      t[d] = rhr[d] * 3600; md[d] = 0; bl[d] = 1'b0; al[d] = 0;
    end else if (md[d] == 0) begin
      if (bm) begin
        t[d] = t[d] - t[d] % 60;
        md[d] = 1;
      end else if (tk) begin
        t[d] = (t[d] + 1) % day;
        dp = (t[d] == 0);
        ah = ALM && (t[d] == al[d] * 60);
      end
    end else begin
      h = t[d] / 3600;
      m = (t[d] / 60) % 60;
      if (bi && !bm) begin
        case (md[d])
          1: h = (h + 1) % (hmax[d] + 1);
          2: m = (m + 1) % 60;
          3: al[d] = ((al[d] / 60 + 1) % (hmax[d] + 1)) * 60 + al[d] % 60;
          4: al[d] = (al[d] / 60) * 60 + (al[d] % 60 + 1) % 60;
          default: ;
        endcase
      end
      t[d] = h * 3600 + m * 60 + t[d] % 60;
      if (tk) bl[d] = !bl[d];
      if (bm) md[d] = nxt_mode(md[d]);
      if (md[d] == 0) bl[d] = 1'b0;
    end
    e.mode  = md[d];
    e.blink = bl[d];
    e.dp    = dp;
    e.ah    = ah;
    e.s     = t[d] % 60;
    if (md[d] >= 3) begin
      e.h = al[d] / 60;
      e.m = al[d] % 60;
    end else begin
      e.h = t[d] / 3600;
      e.m = (t[d] / 60) % 60;
    end
  endtask

  task automatic cyc(input bit rst, input bit tk, input bit bm, input bit bi);
    exp_t e0, e1;
    @(negedge clk);
    reset = rst;
    ifc0.tick_1hz = tk; ifc0.btn_mode = bm; ifc0.btn_inc = bi;
    ifc1.tick_1hz = tk; ifc1.btn_mode = bm; ifc1.btn_inc = bi;
    model(0, rst, tk, bm, bi, e0);
    model(1, rst, tk, bm, bi, e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
    end
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic press();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic to_run();
    for (int i = 0; i < 6 && md[0] != 0; i++) press();
  endtask

  task automatic chk(input string nm, input int d, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, d, $time, act, want);
    end
  endtask

  task automatic cmp(input int d, input exp_t e, input int h, input int m, input int s,
                     input int mo, input int b, input int dp, input int ah);
    chk("hours", d, h, e.h);
    chk("minutes", d, m, e.m);
    chk("seconds", d, s, e.s);
    chk("mode", d, mo, e.mode);
    chk("blink", d, b, int'(e.blink));
    chk("day_pulse", d, dp, int'(e.dp));
    chk("alarm_hit", d, ah, int'(e.ah));
  endtask

  // monitor: every edge after a stimulus cycle has an expected snapshot waiting
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp(0, e, int'(ifc0.hours), int'(ifc0.minutes), int'(ifc0.seconds), int'(ifc0.mode),
            int'(ifc0.blink), int'(ifc0.day_pulse), int'(ifc0.alarm_hit));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp(1, e, int'(ifc1.hours), int'(ifc1.minutes), int'(ifc1.seconds), int'(ifc1.mode),
            int'(ifc1.blink), int'(ifc1.day_pulse), int'(ifc1.alarm_hit));
      end
    end
  end

  initial begin
    ifc0.tick_1hz = 1'b0; ifc0.btn_mode = 1'b0; ifc0.btn_inc = 1'b0;
    ifc1.tick_1hz = 1'b0; ifc1.btn_mode = 1'b0; ifc1.btn_inc = 1'b0;

    // reset state, then a minute of ticks
    do_reset();
    ticks(60);

    // dial dut0 to 23:59, blink toggling in SET, then roll the day over
    press();
    ticks(3);
    incs(11);
    press();
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    incs(57);
    to_run();
    ticks(60);
    idle(2);

    // 12 h dial: dut1 from 11:00 to 11:59:59, one more tick wraps to 00:00:00
    do_reset();
    press();
    press();
    incs(59);
    to_run();
    ticks(60);

    // 12:00:30 -> edit to 15:02 and back to RUN
    do_reset();
    ticks(30);
    press();
    incs(3);
    ticks(2);
    press();
    incs(2);
    ticks(1);
    to_run();
    ticks(3);

    // simultaneous inputs, then reset in the middle of an edit
    do_reset();
    ticks(5);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // alarm at 12:01 from 12:00:00
    do_reset();
    if (ALM) begin
      press(); press(); press();
      incs(12);
      press();
      incs(1);
    end
    to_run();
    ticks(62);

    // random traffic
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
    idle(1);

    for (int i = 0; i < 8 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    #2;
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
